// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN frame scheduler slice.
//   sched_state_e     : scheduler FSM states (IDLE, LAUNCH, WAIT, RESULT)
//   CNN_IMG_W         : flattened image width (8 bits x 144 pixels)
//   CNN_PRED_W        : pipeline class output width
//   CNN_TIMEOUT_CLASS : class value reported for a watchdog-retired frame
//   CNN_WDOG_W        : watchdog counter width (TIMEOUT_CYC up to 2^20-1)
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } sched_state_e;

    localparam int          CNN_IMG_W         = 1152;
    localparam int          CNN_PRED_W        = 32;
    localparam logic [31:0] CNN_TIMEOUT_CLASS = 32'hFFFF_FFFF;
    localparam int          CNN_WDOG_W        = 20;

endpackage

// File: rtl/cnn_sched_watchdog.sv
// cnn_sched_watchdog: loadable up-counter used as the WAIT-state watchdog.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clr_i         : synchronous clear to 0 (highest priority)
//   load_i        : synchronous load of load_val_i
//   load_val_i    : value to load
//   en_i          : count enable (one increment per cycle)
//   count_o       : current count
//   expired_o     : high while count_o == TIMEOUT_CYC-1
// The counter holds at the expiry value instead of wrapping, so a stalled
// enable can never alias back into a fresh count.
module cnn_sched_watchdog
    import cnn_pkg::*;
#(
    parameter int CNT_W       = CNN_WDOG_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != EXP_VAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == EXP_VAL);

endmodule

// File: rtl/cnn_frame_scheduler.sv
// cnn_frame_scheduler: sequences one image at a time through the CNN
// pipeline (start pulse, wait for completion or watchdog, return result).
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   soft_clear_i             : synchronous abort back to IDLE, frame dropped
//   img_valid_i/img_ready_o  : upstream image handshake, img_data_i payload
//   cnn_valid_o              : one-cycle pipeline start pulse
//   cnn_img_o                : image register, stable from launch to retire
//   cnn_ready_i/cnn_predict_i: pipeline completion pulse and class
//   res_valid_o/res_ready_i  : result handshake
//   res_class_o/res_tag_o/res_timeout_o : result payload
//   state_o                  : current FSM state (debug)
// Optional build macro CNN_SCHED_PERF_EN adds perf_frames_o,
// perf_timeouts_o and perf_last_lat_o (saturating, cleared by rst_i only).
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1; valid never waits for ready, and ready never depends on the
// partner's valid (img_ready_o is a pure function of state).
module cnn_frame_scheduler
    import cnn_pkg::*;
#(
    parameter int IMG_W       = CNN_IMG_W,
    parameter int TAG_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_clear_i,
    input  logic                  img_valid_i,
    output logic                  img_ready_o,
    input  logic [IMG_W-1:0]      img_data_i,
    output logic                  cnn_valid_o,
    output logic [IMG_W-1:0]      cnn_img_o,
    input  logic                  cnn_ready_i,
    input  logic [CNN_PRED_W-1:0] cnn_predict_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [CNN_PRED_W-1:0] res_class_o,
    output logic [TAG_W-1:0]      res_tag_o,
    output logic                  res_timeout_o,
    output logic [1:0]            state_o
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_frames_o,
    output logic [15:0]           perf_timeouts_o,
    output logic [19:0]           perf_last_lat_o
`endif
);

    sched_state_e state_q, state_d;

    logic [IMG_W-1:0]      cnn_img_q, cnn_img_d;
    logic [TAG_W-1:0]      tag_cnt_q, tag_cnt_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [CNN_PRED_W-1:0] res_class_q, res_class_d;
    logic                  res_timeout_q, res_timeout_d;

    logic [CNN_WDOG_W-1:0] wd_count;
    logic                  wd_expired;
    logic                  accept;
    logic                  done_ok;
    logic                  done_to;
    logic                  retire;

    // Watchdog restarts from 0 at every launch, so WAIT always sees a fresh
    // count regardless of how the previous frame ended.
    cnn_sched_watchdog #(
        .CNT_W       (CNN_WDOG_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (soft_clear_i),
        .load_i     (state_q == ST_LAUNCH),
        .load_val_i ('0),
        .en_i       (state_q == ST_WAIT),
        .count_o    (wd_count),
        .expired_o  (wd_expired)
    );

    // soft_clear blocks the accept even though img_ready_o is 1 in IDLE:
    // the abort wins over every transition, including a fresh accept.
    assign accept  = (state_q == ST_IDLE) && img_valid_i && !soft_clear_i;
    // Completion beats expiry when both land in the same cycle.
    assign done_ok = (state_q == ST_WAIT) && cnn_ready_i && !soft_clear_i;
    assign done_to = (state_q == ST_WAIT) && !cnn_ready_i && wd_expired && !soft_clear_i;
    assign retire  = (state_q == ST_RESULT) && res_ready_i && !soft_clear_i;

    always_comb begin
        state_d       = state_q;
        cnn_img_d     = cnn_img_q;
        tag_cnt_d     = tag_cnt_q;
        tag_d         = tag_q;
        res_class_d   = res_class_q;
        res_timeout_d = res_timeout_q;
        img_ready_o   = (state_q == ST_IDLE);
        cnn_valid_o   = (state_q == ST_LAUNCH);
        res_valid_o   = (state_q == ST_RESULT);

        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (done_ok || done_to) state_d = ST_RESULT;
            ST_RESULT: if (retire) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (soft_clear_i) begin
            state_d = ST_IDLE;
        end

        if (accept) begin
            cnn_img_d = img_data_i;
            tag_d     = tag_cnt_q;
            tag_cnt_d = tag_cnt_q + TAG_W'(1);
        end

        if (done_ok) begin
            res_class_d   = cnn_predict_i;
            res_timeout_d = 1'b0;
        end else if (done_to) begin
            res_class_d   = CNN_TIMEOUT_CLASS;
            res_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnn_img_q     <= '0;
            tag_cnt_q     <= '0;
            tag_q         <= '0;
            res_class_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnn_img_q     <= cnn_img_d;
            tag_cnt_q     <= tag_cnt_d;
            tag_q         <= tag_d;
            res_class_q   <= res_class_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign cnn_img_o     = cnn_img_q;
    assign res_class_o   = res_class_q;
    assign res_tag_o     = tag_q;
    assign res_timeout_o = res_timeout_q;
    assign state_o       = state_q;

`ifdef CNN_SCHED_PERF_EN
    logic [31:0] perf_frames_q;
    logic [15:0] perf_timeouts_q;
    logic [19:0] perf_last_lat_q;

    // perf_frames counts retired results (normal and timed out).
    // Latency is WAIT cycles including the completion cycle; it cannot
    // overflow because the count stops at TIMEOUT_CYC-1 <= 2^20-2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_frames_q   <= '0;
            perf_timeouts_q <= '0;
            perf_last_lat_q <= '0;
        end else begin
            if (retire && (perf_frames_q != 32'hFFFF_FFFF)) begin
                perf_frames_q <= perf_frames_q + 32'd1;
            end
            if (done_to && (perf_timeouts_q != 16'hFFFF)) begin
                perf_timeouts_q <= perf_timeouts_q + 16'd1;
            end
            if (done_ok) begin
                perf_last_lat_q <= wd_count + 20'd1;
            end
        end
    end

    assign perf_frames_o   = perf_frames_q;
    assign perf_timeouts_o = perf_timeouts_q;
    assign perf_last_lat_o = perf_last_lat_q;
`endif

endmodule
